// File: rtl/llc_proc_update_tx.sv
// Process->update transmit buffer: circular FIFO toward the update stage with flush-marker
// injection, per-table-pointer in-flight tracking and a sticky multi-flag error.
module llc_proc_update_tx #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned TBL_ENTS = 8,
  parameter int unsigned PKT_W    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     proc_valid,
  input  logic [PKT_W-1:0]         proc_data,
  output logic                     proc_ready,
  input  logic                     flush_pipeline_req,
  output logic                     pr_proc_update_valid_out,
  output logic [PKT_W-1:0]         pr_proc_update_data_out,
  input  logic                     pr_proc_update_ready_in,
  output logic [TBL_ENTS-1:0]      inflight_mask,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     err_multi_flag
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned OCC_W     = AW + 1;
  localparam int unsigned PTR_LSB   = 0;
  localparam int unsigned PTR_W     = 3;
  localparam int unsigned FLAG_LSB  = 3;
  localparam int unsigned FLAG_W    = 9;
  localparam int unsigned FLUSH_BIT = 12;

  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] count_q;
  logic [OCC_W-1:0] ptr_cnt_q [TBL_ENTS];
  logic             flush_pending_q, flush_aged_q, err_q;

  logic             valid, deq, room, proc_enq, marker_enq, enq, multi;
  logic [PKT_W-1:0] head, enq_data;
  logic [TBL_ENTS-1:0] inc_vec, dec_vec;

  always_comb begin
    valid      = count_q != '0;
    head       = mem_q[rd_ptr_q];
    deq        = valid && pr_proc_update_ready_in;
    room       = (count_q < OCC_W'(DEPTH)) || deq;
    // A flush that has already yielded once takes the next free slot.
    proc_ready = room && !flush_aged_q;
    proc_enq   = proc_valid && proc_ready;
    marker_enq = flush_pending_q && room && (!proc_valid || flush_aged_q);
    enq        = proc_enq || marker_enq;
    enq_data   = '0;
    if (proc_enq) begin
      enq_data = proc_data;
    end else begin
      enq_data[FLUSH_BIT] = 1'b1;
    end
    multi = $countones(proc_data[FLAG_LSB +: FLAG_W]) > 1;
    for (int p = 0; p < TBL_ENTS; p++) begin
      inc_vec[p] = enq && !enq_data[FLUSH_BIT] && (enq_data[PTR_LSB +: PTR_W] == PTR_W'(p));
      dec_vec[p] = deq && !head[FLUSH_BIT] && (head[PTR_LSB +: PTR_W] == PTR_W'(p));
      inflight_mask[p] = ptr_cnt_q[p] != '0;
    end
    pr_proc_update_valid_out = valid;
    pr_proc_update_data_out  = head;
    occupancy                = count_q;
    err_multi_flag           = err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      for (int p = 0; p < TBL_ENTS; p++) ptr_cnt_q[p] <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      flush_pending_q <= 1'b0;
      flush_aged_q    <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      if (enq) begin
        mem_q[wr_ptr_q] <= enq_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (deq) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + OCC_W'(enq) - OCC_W'(deq);
      // A request arriving while one is pending (or being emitted) merges into it.
      flush_pending_q <= (flush_pending_q && !marker_enq) ||
                         (flush_pipeline_req && !flush_pending_q);
      flush_aged_q    <= flush_pending_q && !marker_enq;
      if (proc_enq && multi) err_q <= 1'b1;
      for (int p = 0; p < TBL_ENTS; p++) begin
        if (inc_vec[p] && !dec_vec[p]) begin
          ptr_cnt_q[p] <= ptr_cnt_q[p] + OCC_W'(1);
        end else if (dec_vec[p] && !inc_vec[p]) begin
          ptr_cnt_q[p] <= ptr_cnt_q[p] - OCC_W'(1);
        end
      end
    end
  end

endmodule
